spi_mem_host: RTL and testbench

Single-lane SPI master that issues memory write/read transactions to the SoC's SPI device port, using the command/address/data framing the device decodes. It sits on the host side, typically in an FPGA test harness or a debug bridge, and converts a valid/ready request into an SPI frame. It returns read data, or a write acknowledge, on a one-cycle response pulse. SPI mode 0: SCLK idles low, the device samples on the rising edge, the host shifts on the falling edge, MSB first.

---
 rtl/spi_mem_host.sv | 195 +++++++++++++++++++
 tb/tb_spi_mem_host.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_host.sv
// SPI mode-0 memory host: turns a valid/ready request into a
// {cmd, addr, data} SPI frame and reports completion on a one-cycle pulse.
module spi_mem_host #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DUMMY_CYCLES = 32,
    parameter int unsigned CS_GAP       = 4,
    parameter logic [7:0]  CMD_WR       = 8'h02,
    parameter logic [7:0]  CMD_RD       = 8'h0B
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // Handshake: a request transfers on a clk_i edge where req_valid_i and
    // req_ready_o are both high; the requester holds valid and its payload
    // stable until then. Responses are a single-cycle rsp_valid_o pulse and
    // cannot be back-pressured.
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o,
    output logic        spi_sclk_o,
    output logic        spi_cs_no,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_TX,
        S_DUMMY,
        S_SHIFT_RX,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0]  HALF_LAST  = 8'(CLK_DIV - 1);
    localparam logic [6:0]  DUMMY_LAST = (DUMMY_CYCLES == 0) ? 7'd0 : 7'(DUMMY_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

    state_t       state_q, state_d;
    logic [7:0]   hcnt_q, hcnt_d;
    logic [6:0]   bcnt_q, bcnt_d;
    logic [15:0]  gcnt_q, gcnt_d;
    logic [71:0]  shreg_q, shreg_d;
    logic [31:0]  rx_q, rx_d;
    logic         we_q, we_d;
    logic         sclk_q, sclk_d;
    logic         cs_n_q, cs_n_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [31:0]  rsp_rdata_q, rsp_rdata_d;
    logic         tick;
    logic [6:0]   last_bit;

    // The outgoing bit is always the MSB of the shift register; it only
    // moves when the register shifts, which happens on SCLK falling edges.
    assign spi_sdo_o   = shreg_q[71];
    assign spi_sclk_o  = sclk_q;
    assign spi_cs_no   = cs_n_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign busy_o      = (state_q != S_IDLE);
    assign tick        = (hcnt_q == HALF_LAST);

    // Next-state and datapath update: half-period ticks toggle SCLK, the
    // bit counter counts SCLK periods within the current phase.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = 8'd0;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;
        shreg_d     = shreg_q;
        rx_d        = rx_q;
        we_d        = we_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        last_bit    = 7'd0;

        case (state_q)
            S_SHIFT_TX: last_bit = we_q ? 7'd71 : 7'd39;
            S_DUMMY:    last_bit = DUMMY_LAST;
            S_SHIFT_RX: last_bit = 7'd31;
            default:    last_bit = 7'd0;
        endcase

        if (state_q inside {S_SETUP, S_SHIFT_TX, S_DUMMY, S_SHIFT_RX, S_HOLD}) begin
            hcnt_d = tick ? 8'd0 : hcnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    state_d = S_SETUP;
                    we_d    = req_we_i;
                    shreg_d = req_we_i ? {CMD_WR, req_addr_i, req_wdata_i}
                                       : {CMD_RD, req_addr_i, 32'h0};
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    bcnt_d  = 7'd0;
                    state_d = S_SHIFT_TX;
                end
            end
            S_SHIFT_TX, S_DUMMY, S_SHIFT_RX: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (state_q == S_SHIFT_RX) begin
                            rx_d = {rx_q[30:0], spi_sdi_i};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        // Zeros shift in behind the payload, so sdo is 0
                        // through dummy, receive and hold.
                        shreg_d = {shreg_q[70:0], 1'b0};
                        if (bcnt_q != last_bit) begin
                            bcnt_d = bcnt_q + 7'd1;
                        end else begin
                            bcnt_d = 7'd0;
                            case (state_q)
                                S_SHIFT_TX: begin
                                    if (we_q)                   state_d = S_HOLD;
                                    else if (DUMMY_CYCLES == 0) state_d = S_SHIFT_RX;
                                    else                        state_d = S_DUMMY;
                                end
                                S_DUMMY: state_d = S_SHIFT_RX;
                                default: state_d = S_HOLD;
                            endcase
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    cs_n_d      = 1'b1;
                    shreg_d     = 72'h0;
                    rsp_valid_d = 1'b1;
                    if (!we_q) begin
                        rsp_rdata_d = rx_q;
                    end
                    gcnt_d  = 16'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            hcnt_q      <= 8'd0;
            bcnt_q      <= 7'd0;
            gcnt_q      <= 16'd0;
            shreg_q     <= 72'h0;
            rx_q        <= 32'h0;
            we_q        <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            we_q        <= we_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_mem_host.sv
// Bench for spi_mem_host: channel 0 uses default timing, channel 1 uses
// CLK_DIV=1 / DUMMY_CYCLES=0. A device model captures host bits on SCLK
// rises, serves reads from a small memory and commits completed writes.
module tb_spi_mem_host;

    localparam logic [7:0] CMD_WR  = 8'h02;
    localparam logic [7:0] CMD_RD  = 8'h0B;
    localparam int         CS_GAP  = 4;
    localparam int         DUMMY0  = 32;
    localparam int         DUMMY1  = 0;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst = 2'b11;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_we = 2'b00;
    logic [31:0] req_addr[2];
    logic [31:0] req_wdata[2];
    logic [1:0]  req_ready, rsp_valid, busy, sclk, cs_n, sdo;
    logic [1:0]  sdi = 2'b00;
    logic [31:0] rsp_rdata[2];

    spi_mem_host u_dut0 (
        .clk_i(clk), .rst_i(rst[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .busy_o(busy[0]),
        .spi_sclk_o(sclk[0]), .spi_cs_no(cs_n[0]), .spi_sdo_o(sdo[0]), .spi_sdi_i(sdi[0])
    );

    spi_mem_host #(.CLK_DIV(1), .DUMMY_CYCLES(0), .CS_GAP(CS_GAP)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .busy_o(busy[1]),
        .spi_sclk_o(sclk[1]), .spi_cs_no(cs_n[1]), .spi_sdo_o(sdo[1]), .spi_sdi_i(sdi[1])
    );

    // scoreboard state
    int n_checks = 0;
    int n_pass   = 0;
    logic [72:0] exp_q[$];
    logic [31:0] mem[logic [32:0]];
    bit abort_exp[2] = '{0, 0};

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // device model / frame monitor
    int cyc = 0;
    int rise_cnt[2], fall_cnt[2], lo_cnt[2], hi_cnt[2], last_lo[2], last_hi[2];
    int last_rises[2], rsp_cnt[2], rsp_bad[2], sdo_bad[2], frames[2];
    int last_rise_cyc[2];
    int per_min[2] = '{1000, 1000};
    int per_max[2] = '{0, 0};
    logic [71:0] cap[2];
    logic [7:0]  fr_cmd[2];
    logic [31:0] fr_addr[2], rd_word[2], rsp_seen[2];
    logic prev_sclk[2] = '{0, 0};
    logic prev_cs[2]   = '{1, 1};
    logic prev_sdo[2]  = '{0, 0};
    int base_v, iv;
    logic [72:0] e;

    // Observe both hosts on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (!cs_n[g] && prev_cs[g]) begin
                last_hi[g] = hi_cnt[g];
                lo_cnt[g] = 0; rise_cnt[g] = 0; fall_cnt[g] = 0; cap[g] = '0;
                per_min[g] = 1000; per_max[g] = 0; sdi[g] = 1'b0;
            end
            if (cs_n[g] && !prev_cs[g]) begin
                last_lo[g] = lo_cnt[g]; last_rises[g] = rise_cnt[g]; frames[g]++;
                hi_cnt[g] = 0;
                if (!abort_exp[g]) begin
                    check($sformatf("ch%0d_frame_queued", g), 80'(exp_q.size() != 0), 80'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("ch%0d_frame_bits", g), 80'({1'(g), cap[g]}), 80'(e));
                    end
                    if (fr_cmd[g] == CMD_WR && rise_cnt[g] == 72)
                        mem[{1'(g), fr_addr[g]}] = cap[g][31:0];
                end
            end
            if (cs_n[g]) hi_cnt[g]++; else lo_cnt[g]++;
            if (sclk[g] && !prev_sclk[g]) begin
                rise_cnt[g]++;
                if (rise_cnt[g] <= 72) cap[g] = {cap[g][70:0], sdo[g]};
                if (rise_cnt[g] == 40) begin
                    fr_cmd[g] = cap[g][39:32];
                    fr_addr[g] = cap[g][31:0];
                end
                if (rise_cnt[g] > 1) begin
                    iv = cyc - last_rise_cyc[g];
                    if (iv < per_min[g]) per_min[g] = iv;
                    if (iv > per_max[g]) per_max[g] = iv;
                end
                last_rise_cyc[g] = cyc;
            end
            if (!sclk[g] && prev_sclk[g]) begin
                fall_cnt[g]++;
                base_v = 40 + ((g == 0) ? DUMMY0 : DUMMY1);
                if (fall_cnt[g] == base_v)
                    rd_word[g] = (fr_cmd[g] == CMD_RD && mem.exists({1'(g), fr_addr[g]}))
                                 ? mem[{1'(g), fr_addr[g]}] : 32'h0;
                if (fall_cnt[g] >= base_v && fall_cnt[g] < base_v + 32)
                    sdi[g] = rd_word[g][31 - (fall_cnt[g] - base_v)];
                else
                    sdi[g] = 1'b0;
            end
            if (sclk[g] && sdo[g] !== prev_sdo[g]) sdo_bad[g]++;
            if (rsp_valid[g]) begin
                rsp_cnt[g]++;
                rsp_seen[g] = rsp_rdata[g];
                if (!(cs_n[g] && !prev_cs[g])) rsp_bad[g]++;
            end
            prev_sclk[g] = sclk[g];
            prev_cs[g]   = cs_n[g];
            prev_sdo[g]  = sdo[g];
        end
    end

    // driver tasks
    task automatic send(input int g, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit expect_frame);
        int n = 0;
        @(negedge clk);
        req_valid[g] = 1'b1; req_we[g] = we; req_addr[g] = addr; req_wdata[g] = wdata;
        if (expect_frame)
            exp_q.push_back(we ? {1'(g), CMD_WR, addr, wdata} : {1'(g), CMD_RD, addr, 32'h0});
        while (!req_ready[g] && n < 2000) begin @(negedge clk); n++; end
        check($sformatf("ch%0d_accept", g), 80'(req_ready[g]), 80'd1);
        @(negedge clk);
        req_valid[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int n = 0;
        while (busy[g] && n < 5000) begin @(negedge clk); n++; end
        check($sformatf("ch%0d_done", g), 80'(busy[g]), 80'd0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rc, fc, n;

    initial begin
        req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
        mem[{1'b0, 32'd100}]    = 32'hDEAD_BEEF;
        mem[{1'b1, 32'h0000_1234}] = 32'hA5C3_0F96;

        // reset state
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("ch%0d_ready_in_reset", g), 80'(req_ready[g]), 80'd0);
            check($sformatf("ch%0d_rst_cs_n", g), 80'(cs_n[g]), 80'd1);
            check($sformatf("ch%0d_rst_sclk", g), 80'(sclk[g]), 80'd0);
            check($sformatf("ch%0d_rst_sdo", g), 80'(sdo[g]), 80'd0);
            check($sformatf("ch%0d_rst_rsp_valid", g), 80'(rsp_valid[g]), 80'd0);
            check($sformatf("ch%0d_rst_rdata", g), 80'(rsp_rdata[g]), 80'd0);
            check($sformatf("ch%0d_rst_busy", g), 80'(busy[g]), 80'd0);
        end
        rst = 2'b00;
        @(negedge clk);
        check("ch0_ready_after_reset", 80'(req_ready[0]), 80'd1);
        check("ch1_ready_after_reset", 80'(req_ready[1]), 80'd1);

        // ch0 read from preloaded device memory
        rc = rsp_cnt[0];
        send(0, 1'b0, 32'd100, 32'h0, 1);
        wait_done(0);
        check("ch0_rd_rises", 80'(last_rises[0]), 80'd104);
        check("ch0_rd_cs_low", 80'(last_lo[0]), 80'd418);
        check("ch0_rd_rsp_cnt", 80'(rsp_cnt[0] - rc), 80'd1);
        check("ch0_rd_rsp_data", 80'(rsp_seen[0]), 80'hDEAD_BEEF);
        check("ch0_rd_sclk_min", 80'(per_min[0]), 80'd4);
        check("ch0_rd_sclk_max", 80'(per_max[0]), 80'd4);

        // ch0 write, read data must hold
        rc = rsp_cnt[0];
        send(0, 1'b1, 32'd100, 32'd100, 1);
        wait_done(0);
        check("ch0_wr_rises", 80'(last_rises[0]), 80'd72);
        check("ch0_wr_cs_low", 80'(last_lo[0]), 80'd290);
        check("ch0_wr_rsp_cnt", 80'(rsp_cnt[0] - rc), 80'd1);
        check("ch0_wr_rdata_held", 80'(rsp_rdata[0]), 80'hDEAD_BEEF);

        // ch0 read back the written word
        send(0, 1'b0, 32'd100, 32'h0, 1);
        wait_done(0);
        check("ch0_rdback_data", 80'(rsp_rdata[0]), 80'h0000_0064);
        check("ch0_cs_gap_min", 80'(last_hi[0] >= CS_GAP + 1), 80'd1);

        // ch0 reset at SCLK rise 30 of a write
        rc = rsp_cnt[0];
        send(0, 1'b1, 32'h40, 32'h1234_5678, 0);
        abort_exp[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (rise_cnt[0] != 30 && n < 2000);
        check("ch0_reach_rise30", 80'(rise_cnt[0]), 80'd30);
        rst[0] = 1'b1;
        @(negedge clk);
        check("ch0_abort_cs_n", 80'(cs_n[0]), 80'd1);
        check("ch0_abort_sclk", 80'(sclk[0]), 80'd0);
        check("ch0_abort_sdo", 80'(sdo[0]), 80'd0);
        check("ch0_abort_rsp_valid", 80'(rsp_valid[0]), 80'd0);
        check("ch0_abort_ready", 80'(req_ready[0]), 80'd0);
        rst[0] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        abort_exp[0] = 1'b0;
        check("ch0_abort_no_rsp", 80'(rsp_cnt[0] - rc), 80'd0);
        check("ch0_abort_rdata_cleared", 80'(rsp_rdata[0]), 80'd0);
        send(0, 1'b1, 32'h20, 32'h1357_9BDF, 1);
        wait_done(0);
        check("ch0_post_reset_rises", 80'(last_rises[0]), 80'd72);
        check("ch0_post_reset_rsp", 80'(rsp_cnt[0] - rc), 80'd1);
        send(0, 1'b0, 32'h20, 32'h0, 1);
        wait_done(0);
        check("ch0_post_reset_rdback", 80'(rsp_rdata[0]), 80'h1357_9BDF);

        // ch1: CLK_DIV=1, no dummy cycles
        send(1, 1'b0, 32'h0000_1234, 32'h0, 1);
        wait_done(1);
        check("ch1_rd_rises", 80'(last_rises[1]), 80'd72);
        check("ch1_rd_cs_low", 80'(last_lo[1]), 80'd145);
        check("ch1_rd_data", 80'(rsp_rdata[1]), 80'hA5C3_0F96);
        check("ch1_sclk_min", 80'(per_min[1]), 80'd2);
        check("ch1_sclk_max", 80'(per_max[1]), 80'd2);

        // ch1: valid held through a frame while the payload changes
        rc = rsp_cnt[1];
        fc = frames[1];
        exp_q.push_back({1'b1, CMD_WR, 32'h10, 32'h1111_1111});
        exp_q.push_back({1'b1, CMD_WR, 32'h20, 32'h2222_2222});
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h10; req_wdata[1] = 32'h1111_1111;
        n = 0;
        while (!req_ready[1] && n < 2000) begin @(negedge clk); n++; end
        check("ch1_hold_first_accept", 80'(req_ready[1]), 80'd1);
        @(negedge clk);
        req_addr[1] = 32'h20; req_wdata[1] = 32'h2222_2222;
        n = 0;
        while (!req_ready[1] && n < 2000) begin @(negedge clk); n++; end
        check("ch1_hold_second_accept", 80'(req_ready[1]), 80'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_done(1);
        check("ch1_hold_frames", 80'(frames[1] - fc), 80'd2);
        check("ch1_hold_rsp_cnt", 80'(rsp_cnt[1] - rc), 80'd2);
        check("ch1_hold_cs_gap", 80'(last_hi[1]), 80'(CS_GAP + 1));
        send(1, 1'b0, 32'h20, 32'h0, 1);
        wait_done(1);
        check("ch1_rd_0x20", 80'(rsp_rdata[1]), 80'h2222_2222);
        send(1, 1'b0, 32'h10, 32'h0, 1);
        wait_done(1);
        check("ch1_rd_0x10", 80'(rsp_rdata[1]), 80'h1111_1111);

        // final report
        for (int g = 0; g < 2; g++) begin
            check($sformatf("ch%0d_sdo_stable_while_sclk_high", g), 80'(sdo_bad[g]), 80'd0);
            check($sformatf("ch%0d_rsp_on_cs_rise", g), 80'(rsp_bad[g]), 80'd0);
        end
        check("exp_q_drained", 80'(exp_q.size()), 80'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
